// File: rtl/ov7670_capture.sv
// OV7670 RGB565 byte-stream capture: pairs bytes into pixels, optionally decimates 2:1
// in both axes, and drives the frame buffer write port.
module ov7670_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned DECIMATE = 1,
  parameter int unsigned FB_DEPTH = 76800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  din,
  output logic [16:0] wraddress,
  output logic [15:0] data,
  output logic        wren,
  output logic        frame_done,
  output logic        overflow
);

  localparam int unsigned XW = $clog2(H_ACTIVE);
  localparam int unsigned YW = $clog2(V_ACTIVE);
  localparam int unsigned AW = 17;

  localparam logic [XW-1:0] X_MAX  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(V_ACTIVE - 1);
  localparam logic [AW-1:0] FB_LIM = AW'(FB_DEPTH);

  localparam logic [1:0] SYNC       = 2'd0;
  localparam logic [1:0] WAIT_FRAME = 2'd1;
  localparam logic [1:0] ACTIVE     = 2'd2;

  logic          vsync_q, href_q, href_qq;
  logic [7:0]    din_q;

  logic [1:0]    state, state_d;
  logic          phase, phase_d;
  logic [7:0]    hi_byte, hi_byte_d;
  logic [XW-1:0] x_cnt, x_cnt_d;
  logic [YW-1:0] y_cnt, y_cnt_d;
  logic [AW-1:0] wraddress_d;
  logic [15:0]   data_d;
  logic          wren_d, frame_done_d, overflow_d;
  logic          keep_c;

  // Camera inputs are registered once; href gets a second stage for falling-edge detection.
  always_ff @(posedge clk) begin
    vsync_q <= vsync;
    href_q  <= href;
    href_qq <= href_q;
    din_q   <= din;
  end

  assign keep_c = (DECIMATE == 0) || (!x_cnt[0] && !y_cnt[0]);

  always_comb begin
    state_d      = state;
    phase_d      = phase;
    hi_byte_d    = hi_byte;
    x_cnt_d      = x_cnt;
    y_cnt_d      = y_cnt;
    wraddress_d  = wraddress;
    data_d       = data;
    wren_d       = 1'b0;
    frame_done_d = 1'b0;
    overflow_d   = overflow;

    // A write strobed last cycle retires its address now, even across frame end.
    if (wren) wraddress_d = wraddress + AW'(1);

    case (state)
      SYNC: begin
        if (vsync_q) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (!vsync_q) begin
          state_d     = ACTIVE;
          wraddress_d = '0;
          x_cnt_d     = '0;
          y_cnt_d     = '0;
          phase_d     = 1'b0;
          overflow_d  = 1'b0;
        end
      end
      ACTIVE: begin
        if (vsync_q) begin
          frame_done_d = 1'b1;
          phase_d      = 1'b0;
          state_d      = WAIT_FRAME;
        end else if (href_q) begin
          phase_d = ~phase;
          if (!phase) begin
            hi_byte_d = din_q;
          end else begin
            if (x_cnt != X_MAX) x_cnt_d = x_cnt + XW'(1);
            if (keep_c) begin
              if (wraddress < FB_LIM) begin
                wren_d = 1'b1;
                data_d = {hi_byte, din_q};
              end else begin
                overflow_d = 1'b1;
              end
            end
          end
        end else if (href_qq) begin
          // Line end drops any unpaired high byte.
          x_cnt_d = '0;
          phase_d = 1'b0;
          if (y_cnt != Y_MAX) y_cnt_d = y_cnt + YW'(1);
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SYNC;
      phase      <= 1'b0;
      hi_byte    <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      wraddress  <= '0;
      data       <= '0;
      wren       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_d;
      phase      <= phase_d;
      hi_byte    <= hi_byte_d;
      x_cnt      <= x_cnt_d;
      y_cnt      <= y_cnt_d;
      wraddress  <= wraddress_d;
      data       <= data_d;
      wren       <= wren_d;
      frame_done <= frame_done_d;
      overflow   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench: a decimating instance (a) and a full-rate instance (b) share one stimulus.
module tb_ov7670_capture;

  logic        clk = 1'b0;
  logic        rst, vsync, href;
  logic [7:0]  din;
  logic [16:0] wraddress_a, wraddress_b;
  logic [15:0] data_a, data_b;
  logic        wren_a, wren_b, frame_done_a, frame_done_b, overflow_a, overflow_b;

  ov7670_capture #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIMATE(1), .FB_DEPTH(8)) dut_a (
    .clk(clk), .rst(rst), .vsync(vsync), .href(href), .din(din),
    .wraddress(wraddress_a), .data(data_a), .wren(wren_a),
    .frame_done(frame_done_a), .overflow(overflow_a)
  );

  ov7670_capture #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIMATE(0), .FB_DEPTH(20)) dut_b (
    .clk(clk), .rst(rst), .vsync(vsync), .href(href), .din(din),
    .wraddress(wraddress_b), .data(data_b), .wren(wren_b),
    .frame_done(frame_done_b), .overflow(overflow_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [16:0] wa_a[$], wa_b[$];
  logic [15:0] wd_a[$], wd_b[$];
  int          wc_a[$];
  int          done_a = 0, done_b = 0, dbl_a = 0, dbl_b = 0;
  logic        pw_a = 1'b0, pw_b = 1'b0;

  // Write/pulse log sampled mid-cycle.
  always @(negedge clk) begin
    if (wren_a) begin wa_a.push_back(wraddress_a); wd_a.push_back(data_a); wc_a.push_back(cyc); end
    if (wren_b) begin wa_b.push_back(wraddress_b); wd_b.push_back(data_b); end
    if (wren_a && pw_a) dbl_a++;
    if (wren_b && pw_b) dbl_b++;
    pw_a = wren_a;
    pw_b = wren_b;
    if (frame_done_a) done_a++;
    if (frame_done_b) done_b++;
  end

  int total = 0, bad = 0;
  int b1_cyc, c1, ba, bb, da, db;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_line(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      href = 1'b1;
      din  = base + 8'(i);
      if (i == 1) b1_cyc = cyc;
      @(negedge clk);
    end
    href = 1'b0;
    din  = 8'h00;
    idle(3);
  endtask

  task automatic frame_start();
    vsync = 1'b1; idle(3);
    vsync = 1'b0; idle(3);
  endtask

  task automatic frame_end();
    vsync = 1'b1; idle(4);
  endtask

  task automatic snap();
    ba = wa_a.size(); bb = wa_b.size(); da = done_a; db = done_b;
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; href = 1'b0; din = 8'h00;
    idle(3);
    chk("rst_addr", 32'(wraddress_a), 32'h0);
    chk("rst_data", 32'(data_a), 32'h0);
    chk("rst_wren", 32'(wren_a), 32'h0);
    chk("rst_done", 32'(frame_done_b), 32'h0);
    chk("rst_ovf", 32'(overflow_b), 32'h0);
    rst = 1'b0; idle(2);

    // href before any vsync is ignored
    snap();
    send_line(8, 8'hA0);
    chk("sync_ign_b", 32'(wa_b.size() - bb), 32'h0);

    // clean frame
    snap();
    frame_start();
    send_line(16, 8'h00); c1 = b1_cyc;
    send_line(16, 8'h00);
    chk("ovf_early_b", 32'(overflow_b), 32'h0);
    send_line(16, 8'h00);
    send_line(16, 8'h00);
    frame_end();
    chk("n_wr_a", 32'(wa_a.size() - ba), 32'd8);
    for (int k = 0; k < 8 && ba + k < wa_a.size(); k++) begin
      chk("addr_a", 32'(wa_a[ba+k]), 32'(k));
      chk("data_a", 32'(wd_a[ba+k]), {16'h0, 8'(4*(k%4)), 8'(4*(k%4)+1)});
    end
    if (wa_a.size() > ba) chk("latency", 32'(wc_a[ba] - c1), 32'd2);
    else chk("latency", 32'hFFFF, 32'd2);
    chk("n_wr_b", 32'(wa_b.size() - bb), 32'd20);
    for (int k = 0; k < 20 && bb + k < wa_b.size(); k++) begin
      chk("addr_b", 32'(wa_b[bb+k]), 32'(k));
      chk("data_b", 32'(wd_b[bb+k]), {16'h0, 8'(2*(k%8)), 8'(2*(k%8)+1)});
    end
    chk("done_a", 32'(done_a - da), 32'd1);
    chk("done_b", 32'(done_b - db), 32'd1);
    chk("ovf_a", 32'(overflow_a), 32'h0);
    chk("ovf_b", 32'(overflow_b), 32'h1);
    chk("hold_addr_a", 32'(wraddress_a), 32'd8);
    chk("hold_addr_b", 32'(wraddress_b), 32'd20);

    // odd-length line then a normal line
    snap();
    frame_start();
    chk("restart_addr_b", 32'(wraddress_b), 32'h0);
    chk("restart_ovf_b", 32'(overflow_b), 32'h0);
    send_line(7, 8'h20);
    send_line(4, 8'h40);
    frame_end();
    chk("odd_n_b", 32'(wa_b.size() - bb), 32'd5);
    if (wa_b.size() - bb == 5) begin
      chk("odd_d0", 32'(wd_b[bb+0]), 32'h2021);
      chk("odd_d2", 32'(wd_b[bb+2]), 32'h2425);
      chk("odd_d3", 32'(wd_b[bb+3]), 32'h4041);
      chk("odd_a3", 32'(wa_b[bb+3]), 32'd3);
      chk("odd_d4", 32'(wd_b[bb+4]), 32'h4243);
    end
    chk("odd_n_a", 32'(wa_a.size() - ba), 32'd2);
    if (wa_a.size() - ba == 2) chk("odd_a_d1", 32'(wd_a[ba+1]), 32'h2425);

    // vsync rises mid-pixel
    snap();
    frame_start();
    send_line(4, 8'h60);
    href = 1'b1; din = 8'h70; @(negedge clk);
    vsync = 1'b1; din = 8'h71; @(negedge clk);
    href = 1'b0; din = 8'h00; idle(4);
    chk("vs_n_b", 32'(wa_b.size() - bb), 32'd2);
    chk("vs_n_a", 32'(wa_a.size() - ba), 32'd1);
    chk("vs_done_b", 32'(done_b - db), 32'd1);
    chk("vs_done_a", 32'(done_a - da), 32'd1);
    frame_start();
    chk("vs_next_addr_a", 32'(wraddress_a), 32'h0);
    chk("vs_next_ovf_b", 32'(overflow_b), 32'h0);

    // reset mid-line while a write is due
    snap();
    href = 1'b1; din = 8'h80; @(negedge clk);
    din = 8'h81; @(negedge clk);
    rst = 1'b1; din = 8'h82; @(negedge clk);
    chk("rst_mid_wren_a", 32'(wren_a), 32'h0);
    chk("rst_mid_wren_b", 32'(wren_b), 32'h0);
    rst = 1'b0;
    for (int i = 3; i < 8; i++) begin din = 8'h80 + 8'(i); @(negedge clk); end
    href = 1'b0; din = 8'h00; idle(3);
    send_line(8, 8'h88);
    chk("rst_skip_b", 32'(wa_b.size() - bb), 32'h0);
    frame_start();
    send_line(4, 8'h90);
    frame_end();
    chk("rst_resume_n_b", 32'(wa_b.size() - bb), 32'd2);
    if (wa_b.size() - bb == 2) begin
      chk("rst_resume_a0", 32'(wa_b[bb]), 32'h0);
      chk("rst_resume_d0", 32'(wd_b[bb]), 32'h9091);
      chk("rst_resume_d1", 32'(wd_b[bb+1]), 32'h9293);
    end
    chk("rst_resume_n_a", 32'(wa_a.size() - ba), 32'd1);

    chk("no_dbl_a", 32'(dbl_a), 32'h0);
    chk("no_dbl_b", 32'(dbl_b), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
